// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int UART_DATA_BITS               = 8;
    localparam int UART_CLKS_PER_BIT_10M_115200 = 87;

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Byte stream from the UART receiver: valid/ready handshake plus error pulses.
interface uart_rx_8n1_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data;
    logic                      valid;
    logic                      ready;
    logic                      frame_err;
    logic                      overrun;

    modport master (output data, valid, frame_err, overrun, input ready);
    modport slave  (input data, valid, frame_err, overrun, output ready);
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs, reset value selectable.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with a one-deep holding register on a valid/ready byte port.
// Optional feature: define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_10M_115200
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          rx,
    uart_rx_8n1_if.master bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_LAG = 1;
`else
    localparam int SAMPLE_LAG = 0;
`endif
    // Only the start bit carries the majority lag; later bits stay a full period apart.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1 + SAMPLE_LAG);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(UART_DATA_BITS - 1);

    logic rx_s, rx_prev, bit_sample;

    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .d_i    (rx),
        .q_o    (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) hist_q <= 2'b11;
        else          hist_q <= {hist_q[0], rx_s};
    end
    assign rx_prev    = hist_q[0];
    assign bit_sample = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    logic hist_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) hist_q <= 1'b1;
        else          hist_q <= rx_s;
    end
    assign rx_prev    = hist_q;
    assign bit_sample = rx_s;
`endif

    uart_rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      stop_ok_q, stop_ok_d;
    logic                      stop_bad_q, stop_bad_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            stop_ok_q   <= 1'b0;
            stop_bad_q  <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            stop_ok_q   <= stop_ok_d;
            stop_bad_q  <= stop_bad_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        stop_ok_d  = 1'b0;
        stop_bad_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev && !rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = bit_sample ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {bit_sample, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop so the next start edge is never missed.
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    state_d    = IDLE;
                    stop_ok_d  = bit_sample;
                    stop_bad_d = !bit_sample;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = stop_bad_q;
        overrun_d   = 1'b0;
        if (stop_ok_q) begin
            if (!valid_q || bus.ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_8n1.sv
// Randomized bench for uart_rx_8n1: drives bit-accurate serial frames and compares
// output events against a frame-level reference model with exact cycle stamps.
module tb_uart_rx_8n1;
    localparam int N = 16;
    localparam int H = N / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 2 + H + 9 * N + 1 + 1;
    localparam bit MAJ = 1'b1;
`else
    localparam int LAT = 2 + H + 9 * N + 1;
    localparam bit MAJ = 1'b0;
`endif
    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_FE   = 2;
    localparam int K_OV   = 3;

    typedef struct {
        int cyc;
        int kind;
        int data;
    } ev_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    logic rx      = 1'b1;
    logic rdy     = 1'b0;
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   model_full = 1'b0;
    logic prev_valid = 1'b0;
    ev_t  obs_q[$];
    ev_t  exp_q[$];

    uart_rx_8n1_if bus ();
    assign bus.ready = rdy;

    uart_rx_8n1 #(.CLKS_PER_BIT(N)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .rx      (rx),
        .bus     (bus)
    );

    always #50 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic ev_t mk_ev(input int c, input int k, input int d);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.data = d;
        return e;
    endfunction

    always begin
        @(posedge clock);
        #1;
        if (bus.valid && !prev_valid) obs_q.push_back(mk_ev(cyc, K_RISE, int'(bus.data)));
        if (!bus.valid && prev_valid) obs_q.push_back(mk_ev(cyc, K_FALL, 0));
        if (bus.frame_err)            obs_q.push_back(mk_ev(cyc, K_FE, 0));
        if (bus.overrun)              obs_q.push_back(mk_ev(cyc, K_OV, 0));
        prev_valid = bus.valid;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Frame outcome from the protocol rules: stop bit low -> frame error; otherwise
    // the byte lands unless a previous byte is still held with ready low.
    task automatic model_frame(input int e0, input logic [7:0] b, input bit stop);
        int t;
        t = e0 + LAT;
        if (!stop) begin
            exp_q.push_back(mk_ev(t, K_FE, 0));
        end else if (model_full && !rdy) begin
            exp_q.push_back(mk_ev(t, K_OV, 0));
        end else begin
            exp_q.push_back(mk_ev(t, K_RISE, int'(b)));
            if (rdy) exp_q.push_back(mk_ev(t + 1, K_FALL, 0));
            else     model_full = 1'b1;
        end
    endtask

    // One 10-bit frame, one line value per clock; optional 1-cycle low spike and reset pulse.
    task automatic drive_frame(input logic [7:0] b, input bit stop, input int spike_i,
                               input int rst_i, output int e0);
        int   bi;
        logic v;
        e0 = cyc + 1;
        for (int i = 0; i < 10 * N; i++) begin
            bi = i / N;
            if (bi == 0)      v = 1'b0;
            else if (bi <= 8) v = b[bi-1];
            else              v = stop;
            if (i == spike_i) v = 1'b0;
            rx = v;
            if (i == rst_i)     reset_n = 1'b0;
            if (i == rst_i + 3) reset_n = 1'b1;
            tick(1);
        end
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit stop);
        int e0;
        drive_frame(b, stop, -1, -100, e0);
        model_frame(e0, b, stop);
    endtask

    task automatic compare_events(input string scen);
        check_eq({scen, "/count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check_eq($sformatf("%s/ev%0d_kind", scen, i), obs_q[i].kind, exp_q[i].kind);
            check_eq($sformatf("%s/ev%0d_cyc", scen, i), obs_q[i].cyc, exp_q[i].cyc);
            check_eq($sformatf("%s/ev%0d_data", scen, i), obs_q[i].data, exp_q[i].data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int          e0;
        int          k;
        logic [7:0]  b;
        logic [7:0]  spike_exp;

        reset_n = 1'b0;
        tick(3);
        check_eq("rst/valid", int'(bus.valid), 0);
        check_eq("rst/data", int'(bus.data), 0);
        check_eq("rst/frame_err", int'(bus.frame_err), 0);
        check_eq("rst/overrun", int'(bus.overrun), 0);
        reset_n = 1'b1;
        tick(5);
        obs_q.delete();

        // Single byte and a run of random bytes with ready held high.
        rdy = 1'b1;
        send(8'hA5, 1'b1);
        tick(3);
        compare_events("a5");
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom_range(0, 255));
            send(b, 1'b1);
            tick($urandom_range(0, 30));
        end
        tick(3);
        compare_events("random");

        // Two bytes back-to-back with nobody accepting: second one is dropped.
        rdy = 1'b0;
        send(8'h3C, 1'b1);
        send(8'h81, 1'b1);
        tick(5);
        compare_events("overrun");
        check_eq("overrun/held_data", int'(bus.data), 'h3C);
        check_eq("overrun/held_valid", int'(bus.valid), 1);
        rdy = 1'b1;
        exp_q.push_back(mk_ev(cyc + 1, K_FALL, 0));
        model_full = 1'b0;
        tick(3);
        compare_events("handshake");
        check_eq("handshake/valid", int'(bus.valid), 0);

        // Short low glitch on an idle line, then a normal byte.
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(H + 4);
        compare_events("glitch");
        send(8'($urandom_range(0, 255)), 1'b1);
        tick(3);
        compare_events("after_glitch");

        // Bad stop bit running into a long break, then recovery.
        send(8'h55, 1'b0);
        rx = 1'b0;
        tick(20 * N);
        rx = 1'b1;
        tick(2 * N);
        send(8'h12, 1'b1);
        tick(3);
        compare_events("break");
        check_eq("break/data", int'(bus.data), 'h12);

        // Reset in the middle of data bit 4 aborts the frame silently.
        drive_frame(8'hFF, 1'b1, -1, 5 * N + H, e0);
        tick(N);
        send(8'h0F, 1'b1);
        tick(3);
        compare_events("midreset");
        check_eq("midreset/data", int'(bus.data), 'h0F);

        // One-cycle low spike at the centre of a random data bit of 0xFF.
        k = $urandom_range(0, 7);
        spike_exp = 8'hFF;
        if (!MAJ) spike_exp[k] = 1'b0;
        drive_frame(8'hFF, 1'b1, (k + 1) * N + H, -100, e0);
        model_frame(e0, spike_exp, 1'b1);
        tick(3);
        compare_events("spike");
        check_eq("spike/data", int'(bus.data), int'(spike_exp));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
